// File: rtl/rebnet_pkg.sv
// rebnet_pkg: shared widths and fetch FSM state encoding for the weight path
package rebnet_pkg;
  localparam int DEF_WEIGHT_LEVELS = 2;
  localparam int DEF_SIMD_WIDTH = 32;
  function automatic int word_width(input int simd, input int levels);
    return simd * levels;
  endfunction
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_t;
endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: 2-entry FIFO whose head register holds its value once emptied
module skid_fifo2 #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);
  logic [DW-1:0] head, tail;
  assign dout = head;
  // head refills from tail or din; tail only takes din when head stays occupied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop && count == 2'd2) head <= tail;
      else if (push && (count == 2'd0 || (count == 2'd1 && pop))) head <= din;
      if (push && (count == 2'd2 || (count == 2'd1 && !pop))) tail <= din;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: credit-limited BRAM burst reader feeding a valid/ready weight stream
module weight_fetch_ctrl
  import rebnet_pkg::*;
#(
  parameter int WEIGHT_LEVELS = DEF_WEIGHT_LEVELS,
  parameter int SIMD_WIDTH    = DEF_SIMD_WIDTH,
  parameter int MEM_DEPTH     = 256,
  parameter int ADDR_W        = $clog2(MEM_DEPTH),
  localparam int DW           = word_width(SIMD_WIDTH, WEIGHT_LEVELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DW-1:0]     mem_rdata,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  fetch_state_t state, next;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0] num_q, issued;
  logic inflight, pop;
  logic [1:0] count;
  logic [2:0] occ;
  skid_fifo2 #(.DW(DW)) u_fifo (
    .clk(clk), .rst(rst), .push(inflight), .pop(pop),
    .din(mem_rdata), .dout(out_data), .count(count)
  );
  assign out_valid = count != 2'd0;
  assign pop = out_valid & out_ready;
  // occupancy after this edge's pop, counting the read still in flight
  assign occ = 3'(count) - 3'(pop) + 3'(inflight);
  assign mem_addr = addr_q;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // read issue under credit, and next-state selection
  always_comb begin
    mem_en = 1'b0;
    next = state;
    mem_en = state == FETCH && issued < num_q && occ < 3'd2;
    next = state == IDLE  ? (start ? (num_words != '0 ? FETCH : DONE) : IDLE) :
           state == FETCH ? (mem_en && issued + (ADDR_W + 1)'(1) == num_q ? DRAIN : FETCH) :
           state == DRAIN ? (occ == 3'd0 ? DONE : DRAIN) : IDLE;
  end
  // state, burst latch, address/issue counters and the 1-cycle read pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      num_q    <= '0;
      issued   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= next;
      inflight <= mem_en;
      if (state == IDLE && start) begin
        addr_q <= base_addr;
        num_q  <= num_words > DEPTH_N ? DEPTH_N : num_words;
        issued <= '0;
      end else if (mem_en) begin
        addr_q <= addr_q == LAST_ADDR ? '0 : addr_q + 1'b1;
        issued <= issued + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// tb_weight_fetch_ctrl: scoreboard bench for the weight fetch controller
module tb_weight_fetch_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] num_words = '0;
  logic mem_en, out_valid, busy, done;
  logic out_ready = 1'b1;
  logic [7:0] mem_addr;
  logic [63:0] mem_rdata = '0, out_data;
  logic [63:0] bram [256];
  logic [63:0] expq [$];
  logic [7:0] addr_log [$];
  logic [7:0] wrap_exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  int errs = 0, checks = 0, cyc = 0, t0 = 0;
  int en_b = 0, x_b = 0, max_pend = 0, first_v = -1, last_v = 0, done_cyc = 0;
  int done_cnt = 0, gaps = 0, burst_n = 0, mode = 0, rph = 0, d0 = 0;
  logic prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  weight_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_en) mem_rdata <= bram[mem_addr];

  always @(posedge clk) begin
    #1;
    if (mode == 1) begin
      out_ready = (rph % 3) == 0;
      rph++;
    end else begin
      out_ready = 1'b1;
      rph = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busy && en_b - x_b > max_pend) max_pend = en_b - x_b;
      if (prev_stall) chk("hold", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("extra_word", 1, 0);
        else chk("word", out_data, expq.pop_front());
        x_b++;
      end
      if (mem_en) begin
        addr_log.push_back(mem_addr);
        en_b++;
      end
      if (!mem_en && en_b > 0 && en_b < burst_n) gaps++;
      if (out_valid && first_v < 0) first_v = cyc - t0;
      if (out_valid) last_v = cyc - t0;
      if (done) begin
        done_cnt++;
        done_cyc = cyc - t0;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end else prev_stall = 1'b0;
  end

  task automatic issue(input logic [7:0] b, input logic [8:0] n);
    int m;
    m = n > 9'd256 ? 256 : int'(n);
    for (int k = 0; k < m; k++) expq.push_back(bram[8'(int'(b) + k)]);
    en_b = 0; x_b = 0; max_pend = 0; first_v = -1; gaps = 0; burst_n = m;
    addr_log.delete();
    base_addr = b; num_words = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) bram[i] = {32'hA500_0000 | 32'(i), 32'(i)};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    d0 = done_cnt;
    issue(8'h10, 9'd8);
    wait_done();
    repeat (3) @(negedge clk);
    chk("stream_first_valid", first_v, 3);
    chk("stream_last_valid", last_v, 10);
    chk("stream_done_cycle", done_cyc, 11);
    chk("stream_done_count", done_cnt - d0, 1);
    chk("stream_words", x_b, 8);
    chk("stream_queue_empty", expq.size(), 0);
    mode = 1;
    d0 = done_cnt;
    issue(8'h20, 9'd6);
    wait_done();
    mode = 0;
    repeat (3) @(negedge clk);
    chk("bp_words", x_b, 6);
    chk("bp_reads", en_b, 6);
    chk("bp_pending_le2", max_pend <= 2, 1);
    chk("bp_credit_stall", gaps > 0, 1);
    chk("bp_done_count", done_cnt - d0, 1);
    chk("bp_queue_empty", expq.size(), 0);
    issue(8'hFE, 9'd4);
    wait_done();
    repeat (3) @(negedge clk);
    chk("wrap_reads", addr_log.size(), 4);
    for (int k = 0; k < 4; k++) if (k < addr_log.size()) chk("wrap_addr", addr_log[k], wrap_exp[k]);
    chk("wrap_queue_empty", expq.size(), 0);
    d0 = done_cnt;
    issue(8'h40, 9'd8);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_words", x_b, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    expq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    issue(8'h50, 9'd3);
    wait_done();
    repeat (3) @(negedge clk);
    chk("post_rst_words", x_b, 3);
    chk("post_rst_queue_empty", expq.size(), 0);
    d0 = done_cnt;
    issue(8'h00, 9'd0);
    @(negedge clk);
    chk("zero_done", done, 1);
    repeat (3) @(negedge clk);
    chk("zero_no_read", en_b, 0);
    chk("zero_done_count", done_cnt - d0, 1);
    d0 = done_cnt;
    issue(8'h80, 9'd4);
    repeat (2) @(posedge clk);
    #1;
    base_addr = 8'h00; num_words = 9'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    num_words = 9'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("ign_reads", en_b, 4);
    chk("ign_words", x_b, 4);
    chk("ign_done_count", done_cnt - d0, 1);
    chk("ign_busy", busy, 0);
    chk("ign_queue_empty", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
